// File: rtl/image_pixel_streamer_if.sv
// Bundle of the frame-buffer write port, start/busy/done control and the
// valid/ready pixel stream that connects the streamer to its host and sink.
interface image_pixel_streamer_if #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
);
  localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              start;
  logic              busy;
  logic              pixel_valid;
  logic              pixel_ready;
  logic [7:0]        pixel_out;
  logic              sof;
  logic              eol;
  logic              eof;
  logic              done;

  modport master (
    input  wr_en, wr_addr, wr_data, start, pixel_ready,
    output busy, pixel_valid, pixel_out, sof, eol, eof, done
  );

  modport slave (
    output wr_en, wr_addr, wr_data, start, pixel_ready,
    input  busy, pixel_valid, pixel_out, sof, eol, eof, done
  );
endinterface

// File: rtl/image_pixel_streamer.sv
// Holds one 8-bit frame in block RAM and replays it in raster order on start,
// with valid/ready flow control, sof/eol/eof markers and a done pulse.
module image_pixel_streamer #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input logic clk,
  input logic rst_n,
  image_pixel_streamer_if.master bus
);
  localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int COL_W  = $clog2(IMG_WIDTH) + 1;
  localparam int ROW_W  = $clog2(IMG_HEIGHT) + 1;

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W:0]   NPIX_EXT  = (ADDR_W + 1)'(NPIX);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

  state_t            state;
  logic [7:0]        mem [NPIX];
  logic [7:0]        rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  nxt_col;
  logic [ROW_W-1:0]  row;
  logic [ROW_W-1:0]  nxt_row;
  logic              xfer;
  logic              advance;
  logic              wr_ok;

  assign xfer    = bus.pixel_valid && bus.pixel_ready;
  assign advance = (state == FETCH) || ((state == STREAM) && xfer);
  assign wr_ok   = bus.wr_en && !bus.busy && ({1'b0, bus.wr_addr} < NPIX_EXT);

  // rd_data always holds the pixel after the one on pixel_out; a stall simply
  // re-reads the same address, so release needs no refill bubble.
  always_comb begin
    rd_addr = rd_addr_q;
    if (state == IDLE)
      rd_addr = '0;
    else if (advance && (rd_addr_q != LAST_ADDR))
      rd_addr = rd_addr_q + 1'b1;
  end

  always_comb begin
    nxt_col = col + 1'b1;
    nxt_row = row;
    if (col == LAST_COL) begin
      nxt_col = '0;
      nxt_row = row + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[bus.wr_addr] <= bus.wr_data;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_addr_q <= '0;
    else
      rd_addr_q <= rd_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.busy        <= 1'b0;
      bus.pixel_valid <= 1'b0;
      bus.pixel_out   <= '0;
      bus.sof         <= 1'b0;
      bus.eol         <= 1'b0;
      bus.eof         <= 1'b0;
      bus.done        <= 1'b0;
      col             <= '0;
      row             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          bus.pixel_valid <= 1'b1;
          bus.pixel_out   <= rd_data;
          bus.sof         <= 1'b1;
          bus.eol         <= (IMG_WIDTH == 1);
          bus.eof         <= (NPIX == 1);
          col             <= '0;
          row             <= '0;
          state           <= STREAM;
        end
        STREAM: begin
          if (xfer) begin
            if (bus.eof) begin
              bus.pixel_valid <= 1'b0;
              bus.sof         <= 1'b0;
              bus.eol         <= 1'b0;
              bus.eof         <= 1'b0;
              bus.done        <= 1'b1;
              bus.busy        <= 1'b0;
              state           <= DONE;
            end else begin
              bus.pixel_out <= rd_data;
              bus.sof       <= 1'b0;
              bus.eol       <= (nxt_col == LAST_COL);
              bus.eof       <= (nxt_col == LAST_COL) && (nxt_row == LAST_ROW);
              col           <= nxt_col;
              row           <= nxt_row;
            end
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/image_pixel_streamer.md
Name: image_pixel_streamer

Overview:
Frame source that feeds the raster pixel stream into the 3x3 window generator and the convolution datapath. It holds one IMG_WIDTH x IMG_HEIGHT 8-bit image in an internal frame buffer, which is loaded through a simple write port. On a start pulse it streams the image in raster order (row 0 col 0 first) with valid/ready flow control and sof/eol/eof markers, then pulses done.

Parameters:
IMG_WIDTH, 28, pixels per row
IMG_HEIGHT, 28, rows per frame
(local) NPIX = IMG_WIDTH*IMG_HEIGHT; ADDR_W = $clog2(NPIX)

Ports:
clk  input  1  clock, all logic rising-edge
rst_n  input  1  asynchronous, active-low reset
wr_en  input  1  frame buffer write strobe
wr_addr  input  ADDR_W  write address, linear raster index row*IMG_WIDTH+col
wr_data  input  8  write pixel
start  input  1  one-cycle request to stream the stored frame
busy  output  1  high from accepted start until done
pixel_valid  output  1  pixel_out/markers valid
pixel_ready  input  1  downstream accepts; tie high for the window generator
pixel_out  output  8  pixel value
sof  output  1  first pixel of frame (row 0, col 0), qualified by pixel_valid
eol  output  1  last pixel of a row (col IMG_WIDTH-1), qualified by pixel_valid
eof  output  1  last pixel of frame, qualified by pixel_valid
done  output  1  one-cycle pulse after the final handshake

Behaviour:
- Reset: busy, pixel_valid, pixel_out, sof, eol, eof, done all 0. FSM goes to IDLE and the read counters go to 0. Frame buffer contents are not reset.
- Frame buffer: synchronous write, synchronous read with 1-cycle latency, suitable for inferring block RAM.
- Writes: accepted only when busy=0 and wr_addr < NPIX. Otherwise they are silently dropped. A write in the same cycle as an accepted start is still performed.
- Handshake: transfer occurs when pixel_valid && pixel_ready.
  - While pixel_valid=1 and pixel_ready=0, pixel_out, sof, eol and eof hold stable.
  - pixel_valid never drops before its transfer.
- FSM states:
  - IDLE: start=1 -> FETCH, busy<=1, read address 0 issued. start is ignored while busy=1.
  - FETCH: first read data returns; pixel_valid rises 2 cycles after the start cycle -> STREAM.
  - STREAM: on each transfer, advance col and row. col wraps IMG_WIDTH-1 -> 0 and increments row. The next pixel is presented the following cycle.
  - After the transfer with eof=1 -> DONE.
  - DONE: done=1 for exactly one cycle, busy<=0, pixel_valid=0 -> IDLE.
- Throughput: with pixel_ready held high, exactly one pixel per cycle with no bubbles, including across row boundaries. A full frame takes NPIX consecutive valid cycles.
- Stall: use a prefetch register or skid entry so that a stall and release costs no extra bubble; the next pixel transfers in the cycle pixel_ready returns.
- Markers:
  - sof=1 only for (0,0).
  - eol=1 for col=IMG_WIDTH-1.
  - eof=1 for (IMG_HEIGHT-1, IMG_WIDTH-1); eol is also 1 on that pixel.
  - All markers are 0 when pixel_valid=0.
- Counters: col is $clog2(IMG_WIDTH)+1 bits and row is $clog2(IMG_HEIGHT)+1 bits, compared exactly; the counters never exceed range.
- start in the same cycle as done: ignored. A new frame needs start while in IDLE.
- Reset mid-frame: the stream aborts immediately with pixel_valid=0 and no done pulse. A later start streams from pixel 0.

Test Plan:
1. Load ramp pixel[i]=i mod 256 for i<784. Pulse start with pixel_ready=1 -> pixel_valid rises 2 cycles after start and stays high 784 consecutive cycles. pixel_out sequence is 0,1,...,255,0,...,15; sof on the 1st pixel only; eol on indices 27,55,...,783; eof on index 783; done pulses 1 cycle later; busy falls with done.
2. Random pixel_ready (50%) on the same frame -> the identical 784-pixel sequence and markers. pixel_out is stable through every stall, and no pixel is duplicated or lost.
3. Write wr_addr=5, data 0xAA during busy, and write wr_addr=784 while idle -> memory unchanged; the next frame shows original pixel 5.
4. Pulse start at pixel 100 mid-frame and in the same cycle as done -> both ignored; exactly one frame is streamed.
5. Assert rst_n=0 at pixel 300 -> outputs 0 asynchronously, no done. After release and start, the stream restarts at pixel 0 with the original data intact.
6. Stream into the window generator (pixel_ready=1) with IMG_WIDTH=IMG_HEIGHT=5 -> 9 valid windows per frame matching the golden model.
